// File: rtl/shear_sort_sequencer.sv
// Phase/step scheduler for a ROWS x COLS shear-sort compare-exchange grid.
// Sequences load, alternating row/column odd-even phases, and completion.
module shear_sort_sequencer #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ROUNDS = 3,
  localparam int RW    = $clog2(ROUNDS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  output logic            load_en,
  output logic            cx_en,
  output logic            step_odd,
  output logic            phase_row,
  output logic [ROWS-1:0] row_desc,
  output logic [RW-1:0]   round,
  output logic            busy,
  output logic            ready,
  output logic            done
);

  localparam int SMAX = (ROWS > COLS) ? ROWS : COLS;
  localparam int SW   = $clog2(SMAX);

  localparam logic [SW-1:0] ROW_LAST = SW'(COLS - 1);
  localparam logic [SW-1:0] COL_LAST = SW'(ROWS - 1);
  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROW,
    S_COL,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_step;
  logic [SW-1:0]   w_step_nxt;
  logic [RW-1:0]   r_round;
  logic [RW-1:0]   w_round_nxt;
  logic [ROWS-1:0] w_snake;
  logic            w_cx_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_round <= w_round_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_round_nxt = r_round;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!hold) begin
          w_state_nxt = S_ROW;
          w_step_nxt  = '0;
          w_round_nxt = '0;
        end
      end
      S_ROW: begin
        if (!hold) begin
          if (r_step == ROW_LAST) begin
            w_step_nxt  = '0;
            w_state_nxt = (r_round == RND_LAST) ? S_DONE : S_COL;
          end else begin
            w_step_nxt = r_step + SW'(1);
          end
        end
      end
      S_COL: begin
        if (!hold) begin
          if (r_step == COL_LAST) begin
            w_step_nxt  = '0;
            w_round_nxt = r_round + RW'(1);
            w_state_nxt = S_ROW;
          end else begin
            w_step_nxt = r_step + SW'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // abort outranks both hold and start
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_step_nxt  = '0;
      w_round_nxt = '0;
    end
  end

  // odd rows sort descending so the grid reads out in snake order
  always_comb begin
    w_snake = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_snake[r] = r[0];
    end
  end

  assign w_cx_state = (r_state == S_ROW) || (r_state == S_COL);

  assign load_en   = (r_state == S_LOAD) && !hold;
  assign cx_en     = w_cx_state && !hold;
  assign step_odd  = w_cx_state && r_step[0];
  assign phase_row = (r_state == S_ROW);
  assign row_desc  = (r_state == S_ROW) ? w_snake : '0;
  assign round     = r_round;
  assign busy      = (r_state != S_IDLE);
  assign ready     = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_shear_sort_sequencer.sv
// Bench for shear_sort_sequencer: default grid plus a 2x8 grid, checked
// cycle by cycle against a schedule built from the sort's phase structure.
module tb_shear_sort_sequencer;

  typedef struct packed {
    logic       load;
    logic       cx;
    logic       row;
    logic       odd;
    logic [7:0] desc;
    logic [1:0] rnd;
    logic       busy;
    logic       ready;
    logic       done;
  } obs_t;

  localparam int K_IDLE = 0;
  localparam int K_LOAD = 1;
  localparam int K_ROW  = 2;
  localparam int K_COL  = 3;
  localparam int K_DONE = 4;

  logic clk;
  logic rst_n;

  logic       start_a, abort_a, hold_a;
  logic       load_a, cx_a, odd_a, prow_a, busy_a, ready_a, done_a;
  logic [3:0] desc_a;
  logic [1:0] rnd_a;

  logic       start_b, abort_b, hold_b;
  logic       load_b, cx_b, odd_b, prow_b, busy_b, ready_b, done_b;
  logic [1:0] desc_b;
  logic [1:0] rnd_b;

  obs_t obs_a, obs_b;

  int n_checks;
  int n_fail;

  obs_t sched_o[$];
  int   sched_k[$];

  shear_sort_sequencer #(.ROWS(4), .COLS(4), .ROUNDS(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .hold(hold_a), .load_en(load_a), .cx_en(cx_a), .step_odd(odd_a),
    .phase_row(prow_a), .row_desc(desc_a), .round(rnd_a),
    .busy(busy_a), .ready(ready_a), .done(done_a)
  );

  shear_sort_sequencer #(.ROWS(2), .COLS(8), .ROUNDS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .hold(hold_b), .load_en(load_b), .cx_en(cx_b), .step_odd(odd_b),
    .phase_row(prow_b), .row_desc(desc_b), .round(rnd_b),
    .busy(busy_b), .ready(ready_b), .done(done_b)
  );

  assign obs_a = {load_a, cx_a, prow_a, odd_a, {4'b0, desc_a}, rnd_a,
                  busy_a, ready_a, done_a};
  assign obs_b = {load_b, cx_b, prow_b, odd_b, {6'b0, desc_b}, rnd_b,
                  busy_b, ready_b, done_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(int kind, int step, int rnd, int rows);
    obs_t o;
    o = '0;
    case (kind)
      K_IDLE: o.ready = 1'b1;
      K_LOAD: begin
        o.busy = 1'b1;
        o.load = 1'b1;
      end
      K_ROW: begin
        o.busy = 1'b1;
        o.cx   = 1'b1;
        o.row  = 1'b1;
        o.odd  = (step % 2) == 1;
        o.rnd  = 2'(rnd);
        for (int r = 0; r < rows; r++) o.desc[r] = (r % 2) == 1;
      end
      K_COL: begin
        o.busy = 1'b1;
        o.cx   = 1'b1;
        o.odd  = (step % 2) == 1;
        o.rnd  = 2'(rnd);
      end
      default: begin
        o.busy = 1'b1;
        o.done = 1'b1;
        o.rnd  = 2'(rnd);
      end
    endcase
    return o;
  endfunction

  task automatic build(input int rows, input int cols, input int rounds);
    sched_o.delete();
    sched_k.delete();
    sched_o.push_back(mk(K_LOAD, 0, 0, rows));
    sched_k.push_back(K_LOAD);
    for (int k = 0; k < rounds; k++) begin
      for (int s = 0; s < cols; s++) begin
        sched_o.push_back(mk(K_ROW, s, k, rows));
        sched_k.push_back(K_ROW);
      end
      if (k < rounds - 1) begin
        for (int s = 0; s < rows; s++) begin
          sched_o.push_back(mk(K_COL, s, k, rows));
          sched_k.push_back(K_COL);
        end
      end
    end
    sched_o.push_back(mk(K_DONE, 0, rounds - 1, rows));
    sched_k.push_back(K_DONE);
  endtask

  task automatic chk(input string tag, input int cyc,
                     input obs_t got, input obs_t exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st,
                       input logic hd, input logic ab);
    if (sel == 0) begin
      start_a = st; hold_a = hd; abort_a = ab;
    end else begin
      start_b = st; hold_b = hd; abort_b = ab;
    end
  endtask

  function automatic obs_t sample(input int sel);
    return (sel == 0) ? obs_a : obs_b;
  endfunction

  // One sort from the IDLE cycle that carries start (cycle 0).
  task automatic run(input string name, input int sel,
                     input int rows, input int cols, input int rounds,
                     input int h_from, input int h_len, input int h_pct,
                     input int ab_at, input int rst_at,
                     input int rs0, input int rs1);
    int   idx, c, holds, n_done, done_cyc, stopped, exp_done;
    logic h, ab, st;
    obs_t e;
    build(rows, cols, rounds);
    drive(sel, 1'b1, 1'b0, 1'b0);
    #1 chk({name, "_idle"}, 0, sample(sel), mk(K_IDLE, 0, 0, rows));
    @(posedge clk); #1;
    c = 1; idx = 0; holds = 0; n_done = 0;
    done_cyc = -1; stopped = 0;
    while (idx < sched_o.size() && c < 500) begin
      h = (sched_k[idx] != K_DONE) &&
          ((c >= h_from && c < h_from + h_len) ||
           ($urandom_range(0, 99) < h_pct));
      ab = (c == ab_at);
      st = (c == rs0) || (c == rs1);
      drive(sel, st, h, ab);
      e = sched_o[idx];
      if (h) begin
        e.load = 1'b0;
        e.cx   = 1'b0;
      end
      #1 chk(name, c, sample(sel), e);
      if (sample(sel).done === 1'b1) begin
        n_done++;
        done_cyc = c;
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1 chk({name, "_async_rst"}, c, sample(sel), mk(K_IDLE, 0, 0, rows));
        @(posedge clk); #1;
        rst_n = 1'b1;
        stopped = 1;
        break;
      end
      @(posedge clk); #1;
      c++;
      if (ab) begin
        stopped = 1;
        break;
      end
      if (h) holds++;
      else idx++;
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    #1 chk({name, "_ready_back"}, c, sample(sel), mk(K_IDLE, 0, 0, rows));
    exp_done = stopped ? -1 : 2 + rounds * cols + (rounds - 1) * rows + holds;
    chk_int({name, "_done_cyc"}, done_cyc, exp_done);
    chk_int({name, "_done_cnt"}, n_done, stopped ? 0 : 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_a", 0, obs_a, mk(K_IDLE, 0, 0, 4));
    chk("reset_b", 0, obs_b, mk(K_IDLE, 0, 0, 2));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("basic", 0, 4, 4, 3, -1, 0, 0, -1, -1, 5, 22);
    run("restart_hold", 0, 4, 4, 3, 7, 3, 0, -1, -1, -1, -1);
    run("abort", 0, 4, 4, 3, -1, 0, 0, 12, -1, -1, -1);
    run("rst_mid", 0, 4, 4, 3, -1, 0, 0, -1, 9, -1, -1);
    for (int i = 0; i < 4; i++) begin
      run($sformatf("rand_a%0d", i), 0, 4, 4, 3, -1, 0, 30,
          -1, -1, int'($urandom_range(2, 30)), -1);
    end
    run("grid2x8", 1, 2, 8, 2, -1, 0, 0, -1, -1, -1, -1);
    run("rand_b", 1, 2, 8, 2, -1, 0, 25, -1, -1, -1, -1);
    run("abort_b", 1, 2, 8, 2, -1, 0, 20,
        int'($urandom_range(1, 19)), -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
